// File: rtl/cache_pmt_sched_pkg.sv
// Shared types and width helpers for the cache permit scheduler.
// The FSM encoding and sizing functions live here so every file agrees on them.
package cache_pmt_sched_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GRANT = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_t;

    localparam int DEFAULT_N_REQ       = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_HOLD_MAX    = 16;
    localparam int DEFAULT_MIN_GAP     = 1;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

    // Width of a grant index for n_req controllers.
    function automatic int id_width(input int n_req);
        return clog2_min1(n_req);
    endfunction

endpackage

// File: rtl/cache_pmt_sched_toggle_edge_sync.sv
// Synchronises one 2-phase toggle input and emits a registered one-cycle pulse per toggle.
// While init_load is high the last-sampled register tracks the chain without producing pulses.
module toggle_edge_sync
    import cache_pmt_sched_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic tgl,
    input  logic init_load,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   last_reg;
    logic                   edge_reg;
    logic                   sync_out;

    assign sync_out   = sync_reg[SYNC_STAGES-1];
    assign edge_pulse = edge_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            last_reg <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], tgl};
            last_reg <= sync_out;
            // Levels present while the chain fills are absorbed, not reported.
            edge_reg <= init_load ? 1'b0 : (sync_out ^ last_reg);
        end
    end

endmodule

// File: rtl/cache_pmt_sched.sv
// Round-robin permit scheduler: grants one cache pipeline controller at a time and
// holds the permit until that controller reports stage-1 completion or the hold limit expires.
module cache_pmt_sched
    import cache_pmt_sched_pkg::*;
#(
    parameter int N_REQ       = DEFAULT_N_REQ,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int HOLD_MAX    = DEFAULT_HOLD_MAX,
    parameter int MIN_GAP     = DEFAULT_MIN_GAP
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    input  logic [N_REQ-1:0]              i_reqTgl,
    input  logic [N_REQ-1:0]              i_doneTgl,
    input  logic                          i_errClr,
    output logic [N_REQ-1:0]              o_pmt,
    output logic                          o_busy,
    output logic [id_width(N_REQ)-1:0]    o_grantId,
    output logic                          o_timeout,
    output logic                          o_err
);

    localparam int ID_W     = id_width(N_REQ);
    localparam int CNT_W    = clog2_min1(HOLD_MAX + 1);
    localparam int INIT_W   = clog2_min1(SYNC_STAGES + 1);
    localparam int GAP_W    = clog2_min1(MIN_GAP + 1);
    localparam int GAP_LAST = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;

    sched_state_t      state_reg;
    logic [INIT_W-1:0] init_cnt_reg;
    logic [N_REQ-1:0]  pending_reg;
    logic [N_REQ-1:0]  pending_next;
    logic [ID_W-1:0]   rr_reg;
    logic [N_REQ-1:0]  pmt_reg;
    logic [ID_W-1:0]   grant_id_reg;
    logic [CNT_W-1:0]  hold_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic              busy_reg;
    logic              timeout_reg;
    logic              err_reg;

    logic [N_REQ-1:0]  req_edge;
    logic [N_REQ-1:0]  done_edge;
    logic              init_load;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic [N_REQ-1:0]  pick_onehot;
    logic              grant_ok;
    logic              grant_done;
    logic              grant_expire;
    logic              grant_release;
    logic              spurious_done;
    logic              err_set;
    logic [ID_W-1:0]   rr_after;

    assign init_load = (state_reg == ST_INIT);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sync
            toggle_edge_sync #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_req_sync (
                .clk        (clk),
                .rst        (rst),
                .tgl        (i_reqTgl[gi]),
                .init_load  (init_load),
                .edge_pulse (req_edge[gi])
            );

            toggle_edge_sync #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_done_sync (
                .clk        (clk),
                .rst        (rst),
                .tgl        (i_doneTgl[gi]),
                .init_load  (init_load),
                .edge_pulse (done_edge[gi])
            );
        end
    endgenerate

    // Scan offsets from far to near so the nearest pending index at or after rr wins.
    always_comb begin
        int cand;
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = (int'(rr_reg) + off) % N_REQ;
            if (pending_reg[cand[ID_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_id    = cand[ID_W-1:0];
            end
        end
    end

    assign pick_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
    assign grant_ok      = i_en && pick_valid;

    assign grant_done    = (state_reg == ST_GRANT) && done_edge[grant_id_reg];
    assign grant_expire  = (state_reg == ST_GRANT) && !grant_done
                           && (hold_cnt_reg == CNT_W'(HOLD_MAX - 1));
    assign grant_release = grant_done || grant_expire;

    // pmt_reg is non-zero only during GRANT, so this flags any done outside the active grant.
    assign spurious_done = |(done_edge & ~pmt_reg);
    assign err_set       = grant_expire || spurious_done;

    assign rr_after      = (grant_id_reg == ID_W'(N_REQ - 1)) ? '0 : grant_id_reg + 1'b1;

    // A fresh request edge beats the release clear on the same channel.
    assign pending_next  = (pending_reg & ~(grant_release ? pmt_reg : '0)) | req_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
            pending_reg  <= '0;
            rr_reg       <= '0;
            pmt_reg      <= '0;
            grant_id_reg <= '0;
            hold_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            busy_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            pending_reg <= pending_next;
            if (err_set) begin
                err_reg <= 1'b1;
            end else if (i_errClr) begin
                err_reg <= 1'b0;
            end

            case (state_reg)
                ST_INIT: begin
                    if (init_cnt_reg == INIT_W'(SYNC_STAGES)) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        init_cnt_reg <= init_cnt_reg + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (grant_ok) begin
                        pmt_reg      <= pick_onehot;
                        grant_id_reg <= pick_id;
                        hold_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    if (grant_release) begin
                        pmt_reg     <= '0;
                        rr_reg      <= rr_after;
                        timeout_reg <= grant_expire;
                        gap_cnt_reg <= '0;
                        if (MIN_GAP == 0) begin
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    // The final gap cycle doubles as the idle decision, so o_pmt is low
                    // for exactly MIN_GAP cycles between back-to-back grants.
                    if (gap_cnt_reg == GAP_W'(GAP_LAST)) begin
                        if (grant_ok) begin
                            pmt_reg      <= pick_onehot;
                            grant_id_reg <= pick_id;
                            hold_cnt_reg <= '0;
                            state_reg    <= ST_GRANT;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_INIT;
                end
            endcase
        end
    end

    assign o_pmt     = pmt_reg;
    assign o_busy    = busy_reg;
    assign o_grantId = grant_id_reg;
    assign o_timeout = timeout_reg;
    assign o_err     = err_reg;

endmodule

// File: tb/tb_cache_pmt_sched.sv
// Self-checking bench for cache_pmt_sched: grant events are scoreboarded against
// expected channel ids queued when the request toggles are driven.
module tb_cache_pmt_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_en = 1'b1;
    logic       i_errClr = 1'b0;
    logic [3:0] i_reqTgl = 4'b0000;
    logic [3:0] i_doneTgl = 4'b0000;
    logic [3:0] o_pmt;
    logic       o_busy;
    logic [1:0] o_grantId;
    logic       o_timeout;
    logic       o_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [3:0] pmt;
        logic [1:0] id;
    } grant_ev_t;

    grant_ev_t  obs_q[$];
    int         exp_id_q[$];
    logic [3:0] prev_pmt = 4'b0000;

    cache_pmt_sched #(
        .N_REQ       (4),
        .SYNC_STAGES (2),
        .HOLD_MAX    (16),
        .MIN_GAP     (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_en      (i_en),
        .i_reqTgl  (i_reqTgl),
        .i_doneTgl (i_doneTgl),
        .i_errClr  (i_errClr),
        .o_pmt     (o_pmt),
        .o_busy    (o_busy),
        .o_grantId (o_grantId),
        .o_timeout (o_timeout),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every rising permit with the cycle it became visible.
    always @(negedge clk) begin
        grant_ev_t ev;
        if (o_pmt != 4'b0000 && prev_pmt == 4'b0000) begin
            ev.cyc = cyc;
            ev.pmt = o_pmt;
            ev.id  = o_grantId;
            obs_q.push_back(ev);
        end
        prev_pmt = o_pmt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(output bit got);
        for (int i = 0; i < 40 && obs_q.size() == 0; i++) tick();
        got = (obs_q.size() > 0);
    endtask

    task automatic wait_release(output bit got, output int fall_cyc);
        got = 1'b0;
        fall_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_pmt == 4'b0000) begin
                got = 1'b1;
                fall_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        i_reqTgl = 4'b1010;
        repeat (3) tick();
        checks++;
        if (o_pmt !== 4'b0000 || o_busy !== 1'b0 || o_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got pmt=%b busy=%b timeout=%b want 0000/0/0", o_pmt, o_busy, o_timeout);
        end
        checks++;
        if (o_err !== 1'b0 || o_grantId !== 2'd0) begin
            failures++;
            $display("FAIL reset_err_id: got err=%b id=%0d want 0/0", o_err, o_grantId);
        end
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            tick();
            if (o_pmt !== 4'b0000 || o_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_high_toggle: got %0d busy cycles, %0d grants want 0/0", bad, obs_q.size());
        end
        checks++;
        if (o_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err_after: got %b want 0", o_err);
        end
    endtask

    task automatic test_single();
        int c, d;
        bit got;
        grant_ev_t ev;
        int exp_id;
        i_reqTgl[2] = ~i_reqTgl[2];
        c = cyc;
        exp_id_q.push_back(2);
        wait_grant(got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL single_grant: got no grant want ch2");
            return;
        end
        ev = obs_q.pop_front();
        exp_id = exp_id_q.pop_front();
        checks++;
        if (ev.pmt !== 4'b0100 || ev.id !== 2'(exp_id) || ev.cyc != c + 5) begin
            failures++;
            $display("FAIL single_grant_val: got pmt=%b id=%0d cyc=%0d want 0100/%0d/%0d", ev.pmt, ev.id, ev.cyc, exp_id, c + 5);
        end
        i_doneTgl[2] = ~i_doneTgl[2];
        d = cyc;
        repeat (3) tick();
        checks++;
        if (o_pmt !== 4'b0100 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL single_hold: got pmt=%b busy=%b at cyc %0d want 0100/1", o_pmt, o_busy, cyc - d);
        end
        tick();
        checks++;
        if (o_pmt !== 4'b0000 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL single_gap: got pmt=%b busy=%b want 0000/1", o_pmt, o_busy);
        end
        tick();
        checks++;
        if (o_pmt !== 4'b0000 || o_busy !== 1'b0 || o_grantId !== 2'd2 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got pmt=%b busy=%b id=%0d err=%b want 0000/0/2/0", o_pmt, o_busy, o_grantId, o_err);
        end
    endtask

    task automatic test_round_robin();
        bit got;
        int fall;
        grant_ev_t ev;
        int exp_id;
        // Service ch0 first so the pointer lands on 1.
        i_reqTgl[0] = ~i_reqTgl[0];
        exp_id_q.push_back(0);
        wait_grant(got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rr_setup: got no grant want ch0");
            return;
        end
        ev = obs_q.pop_front();
        exp_id = exp_id_q.pop_front();
        checks++;
        if (ev.id !== 2'(exp_id) || ev.pmt !== 4'b0001) begin
            failures++;
            $display("FAIL rr_setup_id: got id=%0d pmt=%b want %0d/0001", ev.id, ev.pmt, exp_id);
        end
        i_doneTgl[0] = ~i_doneTgl[0];
        wait_release(got, fall);
        repeat (3) tick();

        i_reqTgl = i_reqTgl ^ 4'b1011;
        exp_id_q.push_back(1);
        exp_id_q.push_back(3);
        exp_id_q.push_back(0);
        fall = -1;
        for (int k = 0; k < 3; k++) begin
            wait_grant(got);
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL rr_grant%0d: got no grant want ch%0d", k, exp_id_q[0]);
                exp_id_q.delete();
                return;
            end
            ev = obs_q.pop_front();
            exp_id = exp_id_q.pop_front();
            checks++;
            if (ev.id !== 2'(exp_id) || ev.pmt !== (4'b0001 << exp_id)) begin
                failures++;
                $display("FAIL rr_order%0d: got id=%0d pmt=%b want id=%0d", k, ev.id, ev.pmt, exp_id);
            end
            if (k > 0) begin
                checks++;
                if (ev.cyc - fall != 1) begin
                    failures++;
                    $display("FAIL rr_gap%0d: got %0d zero cycles want 1", k, ev.cyc - fall);
                end
            end
            i_doneTgl[ev.id] = ~i_doneTgl[ev.id];
            wait_release(got, fall);
        end
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        bit got;
        grant_ev_t ev;
        int exp_id, fall, to_cnt, to_cyc;
        i_reqTgl[1] = ~i_reqTgl[1];
        exp_id_q.push_back(1);
        wait_grant(got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL timeout_grant: got no grant want ch1");
            return;
        end
        ev = obs_q.pop_front();
        exp_id = exp_id_q.pop_front();
        checks++;
        if (ev.id !== 2'(exp_id)) begin
            failures++;
            $display("FAIL timeout_grant_id: got %0d want %0d", ev.id, exp_id);
        end
        fall = -1;
        to_cnt = 0;
        to_cyc = -1;
        repeat (25) begin
            tick();
            if (o_timeout === 1'b1) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (fall < 0 && o_pmt === 4'b0000) fall = cyc;
        end
        checks++;
        if (fall - ev.cyc != 16) begin
            failures++;
            $display("FAIL timeout_len: got %0d cycles high want 16", fall - ev.cyc);
        end
        checks++;
        if (to_cnt != 1 || to_cyc != fall) begin
            failures++;
            $display("FAIL timeout_pulse: got %0d pulses at cyc %0d want 1 at %0d", to_cnt, to_cyc, fall);
        end
        checks++;
        if (o_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_err: got %b want 1", o_err);
        end
        i_errClr = 1'b1;
        tick();
        i_errClr = 1'b0;
        checks++;
        if (o_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_errclr: got %b want 0", o_err);
        end
    endtask

    task automatic test_spurious_done();
        bit got;
        grant_ev_t ev;
        int exp_id, r, fall, to_cnt;
        i_reqTgl[1] = ~i_reqTgl[1];
        exp_id_q.push_back(1);
        wait_grant(got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL spurious_grant: got no grant want ch1");
            return;
        end
        ev = obs_q.pop_front();
        exp_id = exp_id_q.pop_front();
        r = ev.cyc;
        checks++;
        if (ev.id !== 2'(exp_id)) begin
            failures++;
            $display("FAIL spurious_grant_id: got %0d want %0d", ev.id, exp_id);
        end
        i_doneTgl[3] = ~i_doneTgl[3];
        repeat (4) tick();
        checks++;
        if (o_err !== 1'b1 || o_pmt !== 4'b0010) begin
            failures++;
            $display("FAIL spurious_err: got err=%b pmt=%b want 1/0010", o_err, o_pmt);
        end
        tick();
        tick();
        i_errClr = 1'b1;
        tick();
        i_errClr = 1'b0;
        checks++;
        if (o_err !== 1'b0) begin
            failures++;
            $display("FAIL spurious_errclr: got %b want 0", o_err);
        end
        while (cyc < r + 12) tick();
        i_doneTgl[1] = ~i_doneTgl[1];
        fall = -1;
        to_cnt = 0;
        repeat (8) begin
            tick();
            if (o_timeout === 1'b1) to_cnt++;
            if (fall < 0 && o_pmt === 4'b0000) fall = cyc;
        end
        checks++;
        if (fall != r + 16 || to_cnt != 0) begin
            failures++;
            $display("FAIL done_at_timeout: got fall=%0d pulses=%0d want fall=%0d pulses=0", fall - r, to_cnt, 16);
        end
        checks++;
        if (o_err !== 1'b0) begin
            failures++;
            $display("FAIL done_at_timeout_err: got %b want 0", o_err);
        end
    endtask

    task automatic test_enable();
        bit got;
        grant_ev_t ev;
        int exp_id, bad, e, fall;
        i_en = 1'b0;
        i_reqTgl[2] = ~i_reqTgl[2];
        bad = 0;
        repeat (10) begin
            tick();
            if (o_pmt !== 4'b0000 || o_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL enable_block: got %0d busy cycles, %0d grants want 0/0", bad, obs_q.size());
        end
        i_en = 1'b1;
        e = cyc;
        exp_id_q.push_back(2);
        wait_grant(got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL enable_grant: got no grant want ch2");
            return;
        end
        ev = obs_q.pop_front();
        exp_id = exp_id_q.pop_front();
        checks++;
        if (ev.id !== 2'(exp_id) || ev.cyc != e + 1) begin
            failures++;
            $display("FAIL enable_latency: got id=%0d after %0d cycles want id=%0d after 1", ev.id, ev.cyc - e, exp_id);
        end
        i_doneTgl[2] = ~i_doneTgl[2];
        wait_release(got, fall);
        repeat (3) tick();
    endtask

    task automatic test_rst_mid();
        bit got;
        grant_ev_t ev;
        int exp_id, bad, u, fall;
        i_reqTgl[0] = ~i_reqTgl[0];
        exp_id_q.push_back(0);
        wait_grant(got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rstmid_grant: got no grant want ch0");
            return;
        end
        ev = obs_q.pop_front();
        exp_id = exp_id_q.pop_front();
        checks++;
        if (ev.id !== 2'(exp_id) || o_pmt !== 4'b0001) begin
            failures++;
            $display("FAIL rstmid_grant_id: got id=%0d pmt=%b want %0d/0001", ev.id, o_pmt, exp_id);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (o_pmt !== 4'b0000 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: got pmt=%b busy=%b want 0000/0", o_pmt, o_busy);
        end
        i_reqTgl[3] = ~i_reqTgl[3];
        tick();
        tick();
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            tick();
            if (o_pmt !== 4'b0000 || o_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_init: got %0d busy cycles, %0d grants want 0/0", bad, obs_q.size());
        end
        i_reqTgl[3] = ~i_reqTgl[3];
        u = cyc;
        exp_id_q.push_back(3);
        wait_grant(got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rstmid_regrant: got no grant want ch3");
            return;
        end
        ev = obs_q.pop_front();
        exp_id = exp_id_q.pop_front();
        checks++;
        if (ev.id !== 2'(exp_id) || ev.pmt !== 4'b1000 || ev.cyc != u + 5) begin
            failures++;
            $display("FAIL rstmid_regrant_val: got id=%0d pmt=%b lat=%0d want %0d/1000/5", ev.id, ev.pmt, ev.cyc - u, exp_id);
        end
        i_doneTgl[3] = ~i_doneTgl[3];
        wait_release(got, fall);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rstmid_release: got pmt=%b want 0000", o_pmt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_spurious_done();
        test_enable();
        test_rst_mid();
        repeat (5) tick();
        checks++;
        if (obs_q.size() != 0 || exp_id_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d unmatched grants, %0d unserved expectations want 0/0", obs_q.size(), exp_id_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
